// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // The iteration counter must be able to hold the value WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           ge;

    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    // A set top bit means shifted >= 2^WIDTH, which always exceeds the divisor;
    // otherwise the difference fits in WIDTH+1 bits and its top bit is the borrow.
    assign ge = shifted[WIDTH] | ~trial[WIDTH];

    assign rem_next = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider, one quotient bit per clock.
// Optional macro DIV_SEQ_ZERO_TRAP_EN finishes a divide-by-zero after one cycle.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             busy,
    output logic             div_end,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             neg_q;
    logic             neg_r;
    logic             trap_q;
    logic             start;
    logic             last;
    logic             zero_hit;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

`ifdef DIV_SEQ_ZERO_TRAP_EN
    assign zero_hit = (b == '0);
`else
    assign zero_hit = 1'b0;
`endif

    assign busy = (state == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (div) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (trap_q || cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // In a trapped divide quo_q carries the raw dividend so it can be returned as the remainder
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            trap_q   <= 1'b0;
            high     <= '0;
            low      <= '0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_end <= 1'b0;
            if (start) begin
                cnt    <= '0;
                rem_q  <= '0;
                quo_q  <= zero_hit ? a : magnitude(a, is_signed);
                dvsr_q <= magnitude(b, is_signed);
                neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= is_signed & a[WIDTH-1];
                trap_q <= zero_hit;
            end else if (state == RUN) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    div_end  <= 1'b1;
                    div_zero <= trap_q;
                    if (trap_q) begin
                        low  <= '1;
                        high <= quo_q;
                    end else begin
                        low  <= neg_q ? -quo_step : quo_step;
                        high <= neg_r ? -rem_step : rem_step;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at WIDTH=32: directed vectors, corner sequences, random ops.
module tb_div_seq;

    localparam int W = 32;

`ifdef DIV_SEQ_ZERO_TRAP_EN
    localparam int   ZLAT  = 1;
    localparam logic ZFLAG = 1'b1;
`else
    localparam int   ZLAT  = 32;
    localparam logic ZFLAG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         div;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] high;
    logic [W-1:0] low;
    logic         busy;
    logic         div_end;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .high     (high),
        .low      (low),
        .busy     (busy),
        .div_end  (div_end),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one start request; returns at 1ns after the accepting edge
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
        div       = 1'b1;
        is_signed = sgn;
        a         = x;
        b         = y;
        tick();
        div = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!div_end && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // Reference from plain integer arithmetic (truncating division) plus the zero-divisor rules
    task automatic refDiv(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        longint sx, sy, lq, lr;
        if (y == 0) begin
            r   = x;
            z   = ZFLAG;
            lat = ZLAT;
            if (ZFLAG)
                q = '1;
            else
                q = (sgn && x[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
            if (sgn) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'b0, x});
                sy = longint'({32'b0, y});
            end
            lq  = sx / sy;
            lr  = sx % sy;
            q   = lq[W-1:0];
            r   = lr[W-1:0];
            z   = 1'b0;
            lat = 32;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic sgn, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] eq,
                               input logic [W-1:0] er, input logic ez, input int elat);
        int cyc;
        applyStimulus(sgn, x, y);
        checkOutput({tag, " busy"}, 64'(busy), 64'(1));
        waitDone(cyc);
        checkOutput({tag, " latency"}, 64'(cyc), 64'(elat));
        checkOutput({tag, " low"}, 64'(low), 64'(eq));
        checkOutput({tag, " high"}, 64'(high), 64'(er));
        checkOutput({tag, " div_zero"}, 64'(div_zero), 64'(ez));
        checkOutput({tag, " busy at end"}, 64'(busy), 64'(0));
        tick();
        checkOutput({tag, " pulse width"}, 64'(div_end), 64'(0));
        checkOutput({tag, " low held"}, 64'(low), 64'(eq));
        checkOutput({tag, " high held"}, 64'(high), 64'(er));
    endtask

    initial begin
        int            cyc;
        int            seen;
        logic          rs;
        logic [W-1:0]  ra, rb, eq, er;
        logic          ez;
        int            elat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0,  32};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0,  32};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0,  32};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          ZFLAG, ZLAT};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0,  32};
        vecs[5] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0,  32};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0,  32};
        vecs[7] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0,  32};
        vecs[8] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0,  32};
        vecs[9] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0,  32};

        reset     = 1'b1;
        div       = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset div_end", 64'(div_end), 64'(0));
        checkOutput("reset div_zero", 64'(div_zero), 64'(0));
        checkOutput("reset low", 64'(low), 64'(0));
        checkOutput("reset high", 64'(high), 64'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                        vecs[i].lo, vecs[i].hi, vecs[i].zero, vecs[i].lat);
        end

        // Reset in the middle of an operation aborts it silently
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort div_end", 64'(div_end), 64'(0));
        checkOutput("abort low", 64'(low), 64'(0));
        checkOutput("abort high", 64'(high), 64'(0));
        checkOutput("abort div_zero", 64'(div_zero), 64'(0));
        div = 1'b1;
        a   = 32'd100;
        b   = 32'd7;
        tick();
        checkOutput("reset blocks start", 64'(busy), 64'(0));
        reset = 1'b0;
        div   = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (div_end) seen++;
        end
        checkOutput("no div_end after abort", 64'(seen), 64'(0));

        // A start request while busy is ignored
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        div = 1'b1;
        a   = 32'd9;
        b   = 32'd4;
        tick();
        div = 1'b0;
        checkOutput("ignored start busy", 64'(busy), 64'(1));
        waitDone(cyc);
        checkOutput("ignored start latency", 64'(cyc), 64'(27));
        checkOutput("ignored start low", 64'(low), 64'(14));
        checkOutput("ignored start high", 64'(high), 64'(2));

        // Back-to-back: start accepted in the completion cycle
        applyStimulus(1'b0, 32'd9, 32'd4);
        checkOutput("b2b accepted", 64'(busy), 64'(1));
        checkOutput("b2b pulse cleared", 64'(div_end), 64'(0));
        waitDone(cyc);
        checkOutput("b2b latency", 64'(cyc), 64'(32));
        checkOutput("b2b low", 64'(low), 64'(2));
        checkOutput("b2b high", 64'(high), 64'(1));
        tick();

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = 32'($urandom_range(0, 2)) - 32'd1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            refDiv(rs, ra, rb, eq, er, ez, elat);
            runAndCheck($sformatf("rand%0d", i), rs, ra, rb, eq, er, ez, elat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
